// File: rtl/trk_pkg.sv
// Shared definitions for the tracking-loop controller: FSM encoding,
// parameter defaults and the discriminator magnitude helper.
package trk_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLoad   = 3'd1,
      StPullin = 3'd2,
      StTrack  = 3'd3,
      StLost   = 3'd4
   } trk_state_e;

   localparam int unsigned EpochWinDef  = 20;
   localparam logic [31:0] LockThDef    = 32'h0100_0000;
   localparam int unsigned LockCntDef   = 3;
   localparam int unsigned LossCntDef   = 2;
   localparam int unsigned PullinMaxDef = 50;

   // Two's-complement magnitude; 32'h8000_0000 maps to 2^31 as an unsigned value.
   function automatic logic [31:0] disc_mag(input logic [31:0] disc);
      return disc[31] ? (~disc + 32'd1) : disc;
   endfunction

endpackage

// File: rtl/trk_lock_det.sv
// Lock detector window: accumulates |disc| over EPOCH_WIN gated epochs and
// flags whether the completed window sum stayed below LOCK_TH.
module trk_lock_det
   import trk_pkg::*;
#(
   parameter int unsigned EPOCH_WIN = EpochWinDef,
   parameter logic [31:0] LOCK_TH   = LockThDef
) (
   input  logic        rx_clk,
   input  logic        rx_rst,
   input  logic        clr,
   input  logic        sop,
   input  logic [31:0] disc,
   output logic        win_done,
   output logic        win_good
);

   logic [31:0] acc_q, acc_d;
   logic [31:0] epoch_q, epoch_d;
   logic [32:0] acc_sum;
   logic [31:0] acc_sat;

   always_comb begin
      acc_sum  = {1'b0, acc_q} + {1'b0, disc_mag(disc)};
      acc_sat  = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
      win_done = sop && ((epoch_q + 32'd1) >= 32'(EPOCH_WIN));
      // The verdict includes the sample that closes the window.
      win_good = acc_sat < LOCK_TH;
      acc_d    = acc_q;
      epoch_d  = epoch_q;
      if (clr || win_done) begin
         acc_d   = '0;
         epoch_d = '0;
      end else if (sop) begin
         acc_d   = acc_sat;
         epoch_d = epoch_q + 32'd1;
      end
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         acc_q   <= '0;
         epoch_q <= '0;
      end else begin
         acc_q   <= acc_d;
         epoch_q <= epoch_d;
      end
   end

endmodule

// File: rtl/trk_loop_ctrl.sv
// Tracking-loop controller: hands acquisition results to the NCOs, sequences
// pull-in/track/lost via windowed lock detection, and reports lock/failure.
module trk_loop_ctrl
   import trk_pkg::*;
#(
   parameter int unsigned EPOCH_WIN  = EpochWinDef,
   parameter logic [31:0] LOCK_TH    = LockThDef,
   parameter int unsigned LOCK_CNT   = LockCntDef,
   parameter int unsigned LOSS_CNT   = LossCntDef,
   parameter int unsigned PULLIN_MAX = PullinMaxDef
) (
   input  logic        rx_clk,
   input  logic        rx_rst,
   input  logic        acq_valid,
   input  logic [31:0] acq_car_fcw,
   input  logic [31:0] acq_prn_fcw,
   input  logic        trk_abort,
   input  logic        rx_prn_sop,
   input  logic [31:0] rx_pll_disc,
   input  logic [31:0] lpf_car_fcw,
   input  logic [31:0] lpf_prn_fcw,
   output logic        lpf_rst,
   output logic        lpf_prn_sop,
   output logic [31:0] tx_car_fcw,
   output logic [31:0] tx_prn_fcw,
   output logic [2:0]  trk_state,
   output logic        trk_lock,
   output logic        trk_fail,
   output logic        acq_ready
);

   trk_state_e  state_q, state_d;
   logic [31:0] base_car_q, base_car_d;
   logic [31:0] base_prn_q, base_prn_d;
   logic [31:0] tx_car_q, tx_car_d;
   logic [31:0] tx_prn_q, tx_prn_d;
   logic [31:0] good_run_q, good_run_d;
   logic [31:0] win_cnt_q, win_cnt_d;
   logic [31:0] bad_run_q, bad_run_d;
   logic        lock_q, lock_d;
   logic        fail_q, fail_d;
   logic        loop_active;
   logic        det_clr;
   logic        win_done;
   logic        win_good;

   assign loop_active = (state_q == StPullin) || (state_q == StTrack) || (state_q == StLost);
   assign lpf_prn_sop = rx_prn_sop & loop_active;
   assign lpf_rst     = ~loop_active;
   assign acq_ready   = (state_q == StIdle);
   assign trk_state   = state_q;
   assign trk_lock    = lock_q;
   assign trk_fail    = fail_q;
   assign tx_car_fcw  = tx_car_q;
   assign tx_prn_fcw  = tx_prn_q;

   trk_lock_det #(
      .EPOCH_WIN (EPOCH_WIN),
      .LOCK_TH   (LOCK_TH)
   ) u_lock_det (
      .rx_clk   (rx_clk),
      .rx_rst   (rx_rst),
      .clr      (det_clr),
      .sop      (lpf_prn_sop),
      .disc     (rx_pll_disc),
      .win_done (win_done),
      .win_good (win_good)
   );

   always_comb begin
      state_d    = state_q;
      base_car_d = base_car_q;
      base_prn_d = base_prn_q;
      good_run_d = good_run_q;
      win_cnt_d  = win_cnt_q;
      bad_run_d  = bad_run_q;
      lock_d     = lock_q;
      fail_d     = 1'b0;
      det_clr    = 1'b0;

      unique case (state_q)
         StIdle: begin
            lock_d = 1'b0;
            if (acq_valid) begin
               base_car_d = acq_car_fcw;
               base_prn_d = acq_prn_fcw;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            det_clr    = 1'b1;
            good_run_d = '0;
            win_cnt_d  = '0;
            bad_run_d  = '0;
            state_d    = StPullin;
         end
         StPullin: begin
            if (win_done) begin
               win_cnt_d  = win_cnt_q + 32'd1;
               good_run_d = win_good ? good_run_q + 32'd1 : '0;
               // Reaching lock on the last permitted window counts as success.
               if (win_good && ((good_run_q + 32'd1) >= 32'(LOCK_CNT))) begin
                  state_d = StTrack;
                  lock_d  = 1'b1;
               end else if ((win_cnt_q + 32'd1) >= 32'(PULLIN_MAX)) begin
                  state_d = StIdle;
                  fail_d  = 1'b1;
               end
            end
         end
         StTrack: begin
            if (win_done && !win_good) begin
               state_d   = StLost;
               lock_d    = 1'b0;
               bad_run_d = 32'd1;
            end
         end
         StLost: begin
            if (win_done) begin
               if (win_good) begin
                  state_d   = StTrack;
                  lock_d    = 1'b1;
                  bad_run_d = '0;
               end else if ((bad_run_q + 32'd1) >= 32'(LOSS_CNT)) begin
                  state_d = StIdle;
                  fail_d  = 1'b1;
               end else begin
                  bad_run_d = bad_run_q + 32'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            lock_d  = 1'b0;
         end
      endcase

      if (trk_abort) begin
         state_d    = StIdle;
         lock_d     = 1'b0;
         fail_d     = 1'b0;
         base_car_d = base_car_q;
         base_prn_d = base_prn_q;
      end

      if (loop_active) begin
         tx_car_d = base_car_q + lpf_car_fcw;
         tx_prn_d = base_prn_q + lpf_prn_fcw;
      end else begin
         tx_car_d = base_car_q;
         tx_prn_d = base_prn_q;
      end
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         state_q    <= StIdle;
         base_car_q <= '0;
         base_prn_q <= '0;
         tx_car_q   <= '0;
         tx_prn_q   <= '0;
         good_run_q <= '0;
         win_cnt_q  <= '0;
         bad_run_q  <= '0;
         lock_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_car_q <= base_car_d;
         base_prn_q <= base_prn_d;
         tx_car_q   <= tx_car_d;
         tx_prn_q   <= tx_prn_d;
         good_run_q <= good_run_d;
         win_cnt_q  <= win_cnt_d;
         bad_run_q  <= bad_run_d;
         lock_q     <= lock_d;
         fail_q     <= fail_d;
      end
   end

endmodule
